// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage RV32I core.
// Priority per edge is flush > stall > advance; stall/flush event counters saturate.
module if_id_fetch_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP_INST = 32'h0000_0013,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [31:0]      imem_inst,
    output logic [XLEN-1:0]  imem_addr,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [31:0]      if_id_inst,
    output logic             if_id_valid,
    output logic [4:0]       if_id_rs1,
    output logic [4:0]       if_id_rs2,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  if_id_pc_q, if_id_pc_d;
    logic [31:0]      if_id_inst_q, if_id_inst_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        if (flush) begin
            pc_d          = {branch_target[XLEN-1:2], 2'b00};
            if_id_pc_d    = '0;
            if_id_inst_d  = NOP_INST;
            if_id_valid_d = 1'b0;
            if (flush_cnt_q != CNT_MAX)
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (stall) begin
            if (stall_cnt_q != CNT_MAX)
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            pc_d          = pc_q + XLEN'(4);
            if_id_pc_d    = pc_q;
            if_id_inst_d  = imem_inst;
            if_id_valid_d = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_valid = if_id_valid_q;
    // Bubbles report x0 sources so they can never match a load's Rd in the hazard detector.
    assign if_id_rs1   = if_id_valid_q ? if_id_inst_q[19:15] : 5'd0;
    assign if_id_rs2   = if_id_valid_q ? if_id_inst_q[24:20] : 5'd0;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed plan steps plus random stall/flush
// traffic compared against a transaction-level reference model.
module tb_if_id_fetch_stage;

    localparam int          CNT_W   = 4;
    localparam int unsigned CNT_SAT = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             flush;
    logic [31:0]      branch_target;
    logic [31:0]      imem_inst;
    logic [31:0]      imem_addr;
    logic [31:0]      if_id_pc;
    logic [31:0]      if_id_inst;
    logic             if_id_valid;
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the fetch stage should hold after each edge.
    logic [31:0] m_pc, m_ifpc, m_inst;
    logic        m_valid;
    int unsigned m_stalls, m_flushes;

    if_id_fetch_stage #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_inst     (imem_inst),
        .imem_addr     (imem_addr),
        .if_id_pc      (if_id_pc),
        .if_id_inst    (if_id_inst),
        .if_id_valid   (if_id_valid),
        .if_id_rs1     (if_id_rs1),
        .if_id_rs2     (if_id_rs2),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address, so every PC has a distinct word.
    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= CNT_SAT) ? CNT_SAT : v + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_ifpc    = 32'h0;
        m_inst    = NOP;
        m_valid   = 1'b0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    task automatic check_all(input string tag);
        logic [4:0] e_rs1, e_rs2;
        e_rs1 = m_valid ? m_inst[19:15] : 5'd0;
        e_rs2 = m_valid ? m_inst[24:20] : 5'd0;
        check({tag, ".imem_addr"},   imem_addr,            m_pc);
        check({tag, ".if_id_pc"},    if_id_pc,             m_ifpc);
        check({tag, ".if_id_inst"},  if_id_inst,           m_inst);
        check({tag, ".if_id_valid"}, 32'(if_id_valid),     32'(m_valid));
        check({tag, ".rs1"},         32'(if_id_rs1),       32'(e_rs1));
        check({tag, ".rs2"},         32'(if_id_rs2),       32'(e_rs2));
        check({tag, ".stall_count"}, 32'(stall_count),     m_stalls);
        check({tag, ".flush_count"}, 32'(flush_count),     m_flushes);
    endtask

    // One clock cycle: drive inputs between edges, advance the model at the edge, then compare.
    task automatic step(input string tag, input logic st, input logic fl, input logic [31:0] tgt);
        stall         = st;
        flush         = fl;
        branch_target = tgt;
        imem_inst     = imem_word(m_pc);
        @(posedge clk);
        if (fl) begin
            m_pc      = tgt & 32'hFFFF_FFFC;
            m_ifpc    = 32'h0;
            m_inst    = NOP;
            m_valid   = 1'b0;
            m_flushes = sat_inc(m_flushes);
        end else if (st) begin
            m_stalls = sat_inc(m_stalls);
        end else begin
            m_ifpc  = m_pc;
            m_inst  = imem_word(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0; imem_inst = '0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // Free-running fetch.
        step("adv0", 1'b0, 1'b0, 32'h0);
        step("adv1", 1'b0, 1'b0, 32'h0);
        check("pc_at_8", imem_addr, 32'h8);

        // Two-cycle stall at pc=8 holds the pc=4 instruction.
        step("stall0", 1'b1, 1'b0, 32'h0);
        step("stall1", 1'b1, 1'b0, 32'h0);
        check("stall_hold_pc", if_id_pc, 32'h4);
        check("stall_cnt2", 32'(stall_count), 32'd2);
        step("release", 1'b0, 1'b0, 32'h0);
        check("release_inst", if_id_inst, imem_word(32'h8));

        // Flush drops the low target bits and inserts a bubble.
        step("flush", 1'b0, 1'b1, 32'h0000_0103);
        check("flush_pc", imem_addr, 32'h100);
        check("flush_nop", if_id_inst, NOP);
        step("adv_after_flush", 1'b0, 1'b0, 32'h0);

        // Flush wins over a simultaneous stall.
        step("flush_stall", 1'b1, 1'b1, 32'h0000_0040);
        check("fs_pc", imem_addr, 32'h40);
        check("fs_stall_cnt", 32'(stall_count), 32'd2);
        check("fs_flush_cnt", 32'(flush_count), 32'd2);

        // PC wraps from the top of the address space.
        step("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap", 1'b0, 1'b0, 32'h0);
        check("wrap_pc", imem_addr, 32'h0);
        check("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);

        // Long stall saturates the narrow counter.
        for (int i = 0; i < (1 << CNT_W) + 5; i++) step("long_stall", 1'b1, 1'b0, 32'h0);
        check("stall_sat", 32'(stall_count), CNT_SAT);

        // Random traffic, including enough flushes to saturate flush_count.
        for (int i = 0; i < 300; i++) begin
            logic       st, fl;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            tgt = $urandom;
            step("rand", st, fl, tgt);
        end
        check("flush_sat", 32'(flush_count), CNT_SAT);

        // Asynchronous reset in the middle of a stall, well away from any clock edge.
        step("pre_rst_stall", 1'b1, 1'b0, 32'h0);
        stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_all("rst_held");
        rst = 1'b0;
        step("post_rst0", 1'b0, 1'b0, 32'h0);
        step("post_rst1", 1'b0, 1'b0, 32'h0);
        check("post_rst_pc", imem_addr, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
